// File: rtl/cache_fill_if.sv
// Signal bundle between a cache, its fill controller and main memory.
// The master modport is the cache/memory side, slave is the fill controller.
interface cache_fill_if;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        memory_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] fill_address;
  logic [15:0] fill_data;

  modport master (
    output miss_detected, miss_address, memory_data, memory_data_valid,
    input  fsm_busy, memory_read, memory_address, write_data_array,
           write_tag_array, fill_address, fill_data
  );

  modport slave (
    input  miss_detected, miss_address, memory_data, memory_data_valid,
    output fsm_busy, memory_read, memory_address, write_data_array,
           write_tag_array, fill_address, fill_data
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches a 16-byte block as 8 word reads and
// writes each returned word, then the tag, into the requesting cache.
//
// state | meaning
// IDLE  | waiting for a miss; all outputs except fill_data low
// FILL  | issuing 8 reads and writing 8 returned words; tag with the last
module cache_fill_fsm (
  input  logic         clk,
  input  logic         rst,
  cache_fill_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [11:0] base_q, base_d;
  logic [3:0]  issue_cnt_q, issue_cnt_d;
  logic [2:0]  recv_cnt_q, recv_cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    base_d               = base_q;
    issue_cnt_d          = issue_cnt_q;
    recv_cnt_d           = recv_cnt_q;
    bus.fsm_busy         = 1'b0;
    bus.memory_read      = 1'b0;
    bus.memory_address   = '0;
    bus.write_data_array = 1'b0;
    bus.write_tag_array  = 1'b0;
    bus.fill_address     = '0;
    bus.fill_data        = bus.memory_data;

    case (state_q)
      IDLE: begin
        if (bus.miss_detected) begin
          base_d      = bus.miss_address[15:4];
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = FILL;
        end
      end
      FILL: begin
        bus.fsm_busy = 1'b1;
        // Word offsets come from the counters only, so addresses never carry into base.
        if (issue_cnt_q < 4'd8) begin
          bus.memory_read    = 1'b1;
          bus.memory_address = {base_q, issue_cnt_q[2:0], 1'b0};
          issue_cnt_d        = issue_cnt_q + 4'd1;
        end
        if (bus.memory_data_valid) begin
          bus.write_data_array = 1'b1;
          bus.fill_address     = {base_q, recv_cnt_q, 1'b0};
          recv_cnt_d           = recv_cnt_q + 3'd1;
          if (recv_cnt_q == 3'd7) begin
            bus.write_tag_array = 1'b1;
            state_d             = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
